// File: rtl/adc_avg_filter.sv
// ----------------------------------------------------------------------------
// adc_avg_filter
//
// Moving-average filter between the XADC conversion output and the voltage
// comparator / max-voltage register array. One W-bit sample is taken per
// end-of-conversion strobe. The mean of the last N = 2^LOG2_N samples is
// published as a registered value with a one-cycle valid pulse. No partial-
// window average is ever published, so single-sample noise cannot register
// as a new maximum during the servo sweep.
//
// Ports:
//   clk          system clock (PLL domain, same as the XADC)
//   rst_n        asynchronous active-low reset
//   sample_valid one-cycle strobe, sample is valid this cycle (from AdcEoc)
//   sample       raw ADC code, W bits
//   clr          synchronous clear of window and state; wins over sample_valid
//   avg          windowed mean, registered, truncating divide by N
//   avg_valid    one-cycle pulse, one clk after each accept in a full window
//   filled       high once N samples have been accepted since reset or clr
// ----------------------------------------------------------------------------
module adc_avg_filter #(
    parameter int W      = 12,
    parameter int LOG2_N = 3     // legal 1..4, window depth N = 2..16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sample_valid,
    input  logic [W-1:0] sample,
    input  logic         clr,
    output logic [W-1:0] avg,
    output logic         avg_valid,
    output logic         filled
);

    localparam int N  = 1 << LOG2_N;
    localparam int SW = W + LOG2_N;   // N * (2^W - 1) always fits

    localparam logic [LOG2_N:0]   CNT_LAST = (LOG2_N + 1)'(N - 1);
    localparam logic [LOG2_N:0]   CNT_ONE  = (LOG2_N + 1)'(1);
    localparam logic [LOG2_N-1:0] WP_ONE   = LOG2_N'(1);

    typedef enum logic {
        FILL = 1'b0,   // fewer than N samples held
        RUN  = 1'b1    // window full, every accept publishes an average
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      sample_buf [N];
    logic [LOG2_N-1:0] wp_q, wp_d;
    logic [LOG2_N:0]   cnt_q, cnt_d;
    logic [SW-1:0]     sum_q, sum_d, new_sum;
    logic [W-1:0]      avg_d;
    logic              avg_valid_d;
    logic              filled_d;
    logic              buf_we;

    // The slot at wp holds the oldest sample (or 0 while filling), so one
    // add and one subtract keep the sum exact. The intermediate can wrap
    // modulo 2^SW, but the true result is always in range.
    always_comb begin
        new_sum = sum_q + SW'(sample) - SW'(sample_buf[wp_q]);
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        avg_d       = avg;
        avg_valid_d = 1'b0;
        filled_d    = filled;
        buf_we      = 1'b0;

        if (clr) begin
            state_d  = FILL;
            wp_d     = '0;
            cnt_d    = '0;
            sum_d    = '0;
            avg_d    = '0;
            filled_d = 1'b0;
        end else if (sample_valid) begin
            buf_we = 1'b1;
            sum_d  = new_sum;
            wp_d   = wp_q + WP_ONE;
            unique case (state_q)
                FILL: begin
                    cnt_d = cnt_q + CNT_ONE;
                    // This accept completes the window: publish straight away.
                    if (cnt_q == CNT_LAST) begin
                        state_d     = RUN;
                        filled_d    = 1'b1;
                        avg_d       = new_sum[SW-1:LOG2_N];
                        avg_valid_d = 1'b1;
                    end
                end
                RUN: begin
                    avg_d       = new_sum[SW-1:LOG2_N];
                    avg_valid_d = 1'b1;
                end
                default: state_d = FILL;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            wp_q      <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
            filled    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wp_q      <= wp_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            avg       <= avg_d;
            avg_valid <= avg_valid_d;
            filled    <= filled_d;
        end
    end

    // NOTE: the sample buffer must be reset and cleared, unlike a plain data
    // RAM. The fill phase relies on evicting zeros to keep the sum exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) sample_buf[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < N; i++) sample_buf[i] <= '0;
        end else if (buf_we) begin
            sample_buf[wp_q] <= sample;
        end
    end

endmodule

// File: tb/tb_adc_avg_filter.sv
// ----------------------------------------------------------------------------
// tb_adc_avg_filter
//
// Self-checking bench for adc_avg_filter (W=12, LOG2_N=3). A behavioural
// model keeps the accepted-sample history in a queue and computes the mean
// by summing it. One compare process checks avg / avg_valid / filled against
// the model on every falling edge. Directed scenarios add literal
// expectations on the captured output stream, and a randomized phase follows.
// ----------------------------------------------------------------------------
module tb_adc_avg_filter;

    localparam int W      = 12;
    localparam int LOG2_N = 3;
    localparam int N      = 1 << LOG2_N;

    logic         clk          = 1'b0;
    logic         rst_n        = 1'b0;
    logic         sample_valid = 1'b0;
    logic [W-1:0] sample       = '0;
    logic         clr          = 1'b0;
    logic [W-1:0] avg;
    logic         avg_valid;
    logic         filled;

    adc_avg_filter #(.W(W), .LOG2_N(LOG2_N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .clr          (clr),
        .avg          (avg),
        .avg_valid    (avg_valid),
        .filled       (filled)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           hist[$];
    logic [W-1:0] m_avg;
    logic         m_valid;
    logic         m_filled;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            hist.delete();
            m_avg    = '0;
            m_valid  = 1'b0;
            m_filled = 1'b0;
        end else if (sample_valid) begin
            int s;
            hist.push_back(int'(sample));
            if (hist.size() > N) void'(hist.pop_front());
            if (hist.size() == N) begin
                s = 0;
                foreach (hist[i]) s += hist[i];
                m_avg    = W'(s / N);
                m_valid  = 1'b1;
                m_filled = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end else begin
            m_valid = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("avg", 32'(avg), 32'(m_avg));
        check("avg_valid", 32'(avg_valid), 32'(m_valid));
        check("filled", 32'(filled), 32'(m_filled));
    end

    // Captured output stream for the directed literal checks.
    logic [W-1:0] seen[$];
    always @(negedge clk) if (avg_valid) seen.push_back(avg);

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [W-1:0] s, input logic c);
        @(posedge clk);
        #1;
        sample_valid = v;
        sample       = s;
        clr          = c;
    endtask

    task automatic idle(input int cycles);
        drive(1'b0, '0, 1'b0);
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    task automatic burst(input int count, input logic [W-1:0] s);
        for (int i = 0; i < count; i++) drive(1'b1, s, 1'b0);
    endtask

    logic [W-1:0] steps [9];
    int           spikes;

    initial begin
        steps = '{12'h000, 12'h1FF, 12'h3FF, 12'h5FF, 12'h7FF,
                  12'h9FF, 12'hBFF, 12'hDFF, 12'hFFF};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_avg", 32'(avg), 32'h0);
        check("reset_valid", 32'(avg_valid), 32'h0);
        check("reset_filled", 32'(filled), 32'h0);

        // First window: 7 samples publish nothing, the 8th publishes 0x100
        seen.delete();
        burst(7, 12'h100);
        idle(1);
        check("fill_no_pulse", 32'(seen.size()), 32'd0);
        check("fill_not_filled", 32'(filled), 32'h0);
        drive(1'b1, 12'h100, 1'b0);
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        check("first_avg", 32'(avg), 32'h100);
        check("first_valid", 32'(avg_valid), 32'h1);
        check("first_filled", 32'(filled), 32'h1);

        // Zeros then full scale back-to-back: linear truncated steps
        drive(1'b0, '0, 1'b1);
        seen.delete();
        burst(8, 12'h000);
        burst(8, 12'hFFF);
        idle(2);
        check("step_count", 32'(seen.size()), 32'd9);
        for (int i = 0; i < 9 && i < seen.size(); i++)
            check($sformatf("step_%0d", i), 32'(seen[i]), 32'(steps[i]));

        // Spike through the window proves the wp wrap
        seen.delete();
        burst(8, 12'h800);
        drive(1'b1, 12'hFFF, 1'b0);
        burst(10, 12'h800);
        idle(2);
        check("spike_count_total", 32'(seen.size()), 32'd19);
        if (seen.size() == 19) begin
            check("spike_base", 32'(seen[7]), 32'h800);
            spikes = 0;
            for (int i = 8; i < 19; i++) if (seen[i] == 12'h8FF) spikes++;
            check("spike_outputs", 32'(spikes), 32'd8);
            check("spike_first", 32'(seen[8]), 32'h8FF);
            check("spike_gone", 32'(seen[16]), 32'h800);
        end

        // clr together with sample_valid in RUN: the sample is dropped
        drive(1'b1, 12'hABC, 1'b1);
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        check("clr_filled", 32'(filled), 32'h0);
        check("clr_avg", 32'(avg), 32'h0);
        check("clr_valid", 32'(avg_valid), 32'h0);
        seen.delete();
        burst(7, 12'h200);
        idle(2);
        check("clr_seven_no_pulse", 32'(seen.size()), 32'd0);
        drive(1'b1, 12'h200, 1'b0);
        idle(2);
        check("clr_eighth_pulse", 32'(seen.size()), 32'd1);
        if (seen.size() == 1) check("clr_eighth_avg", 32'(seen[0]), 32'h200);

        // Asynchronous reset in RUN: outputs clear without a clock edge
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_run_avg", 32'(avg), 32'h0);
        check("arst_run_filled", 32'(filled), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Asynchronous reset mid-fill (cnt=5) discards history
        burst(5, 12'hFFF);
        @(posedge clk);
        #3 rst_n = 1'b0;
        sample_valid = 1'b0;
        #1;
        check("arst_fill_filled", 32'(filled), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen.delete();
        burst(7, 12'h040);
        idle(2);
        check("arst_seven_no_pulse", 32'(seen.size()), 32'd0);
        drive(1'b1, 12'h040, 1'b0);
        idle(2);
        check("arst_eighth_pulse", 32'(seen.size()), 32'd1);
        if (seen.size() == 1) check("arst_eighth_avg", 32'(seen[0]), 32'h040);

        // Real XADC rate, alternating codes
        drive(1'b0, '0, 1'b1);
        seen.delete();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, (i % 2 == 0) ? 12'h123 : 12'h456, 1'b0);
            drive(1'b0, '0, 1'b0);
            repeat (2198) @(posedge clk);
        end
        #2;
        check("xadc_pulses", 32'(seen.size()), 32'd5);
        foreach (seen[i]) check($sformatf("xadc_avg_%0d", i), 32'(seen[i]), 32'h2BC);

        // Randomized phase: dense/sparse strobes, occasional clr, extremes
        for (int i = 0; i < 4000; i++) begin
            logic [W-1:0] s;
            int           kind;
            kind = int'($urandom_range(0, 9));
            s    = (kind == 0) ? 12'hFFF : (kind == 1) ? 12'h000 : W'($urandom);
            drive($urandom_range(0, 3) != 0, s, $urandom_range(0, 199) == 0);
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
